// File: rtl/booth_pkg.sv
// booth_pkg: shared FSM states, Booth digit encoding and helpers for the radix-4 multiplier.
package booth_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} digit_t;
  function automatic int iter_count(input int width);
    return (width + 2) / 2;
  endfunction
  function automatic digit_t booth_digit(input logic [2:0] w);
    case (w)
      3'b001, 3'b010: return POS1;
      3'b011:         return POS2;
      3'b100:         return NEG2;
      3'b101, 3'b110: return NEG1;
      default:        return ZERO;
    endcase
  endfunction
endpackage

// File: rtl/booth_radix4_recoder.sv
// booth_radix4_recoder: maps a 3-bit Booth window to the signed multiple of the extended multiplicand.
module booth_radix4_recoder
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]              win_i,
  input  logic [WIDTH+1:0]        m_i,
  output logic signed [WIDTH+2:0] mult_o
);
  digit_t dig;
  logic signed [WIDTH+2:0] m1, m2;
  always_comb begin
    dig    = booth_digit(win_i);
    m1     = {m_i[WIDTH+1], m_i};
    m2     = {m_i, 1'b0};
    mult_o = dig == POS1 ? m1 : dig == POS2 ? m2 : dig == NEG1 ? -m1 : dig == NEG2 ? -m2 : '0;
  end
endmodule

// File: rtl/seq_booth_multiplier.sv
// seq_booth_multiplier: iterative radix-4 Booth multiplier, two multiplier bits per clock,
// valid/ready on both sides, runtime signed/unsigned operands.
module seq_booth_multiplier
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     M,
  input  logic [WIDTH-1:0]     Q,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 busy
);
  localparam int ITER = iter_count(WIDTH);
  localparam int XW   = WIDTH + 2;
  localparam int PW   = 2 * WIDTH + 4;
  localparam int CW   = $clog2(ITER + 1);
  state_t                state_q, state_d;
  logic [XW-1:0]         m_q, m_d, q_q, q_d;
  logic                  g_q, g_d;
  logic [PW-1:0]         p_q, p_d, addend;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2*WIDTH-1:0]    res_q, res_d;
  logic signed [WIDTH+2:0] mult;
  booth_radix4_recoder #(.WIDTH(WIDTH)) u_rec (
    .win_i  ({q_q[1:0], g_q}),
    .m_i    (m_q),
    .mult_o (mult)
  );
  // q_q shifts right two bits per step, so the window always sits at the bottom;
  // the digit is sign-extended to P's width and placed at weight 4^k.
  assign addend = PW'(mult) << {cnt_q, 1'b0};
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    q_d     = q_q;
    g_d     = g_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    case (state_q)
      IDLE: if (in_valid) begin
        m_d     = signed_mode ? {{2{M[WIDTH-1]}}, M} : {2'b00, M};
        q_d     = signed_mode ? {{2{Q[WIDTH-1]}}, Q} : {2'b00, Q};
        g_d     = 1'b0;
        p_d     = '0;
        cnt_d   = '0;
        state_d = BUSY;
      end
      BUSY: begin
        p_d   = p_q + addend;
        q_d   = q_q >> 2;
        g_d   = q_q[1];
        cnt_d = CW'(cnt_q + 1'b1);
        if (cnt_q == CW'(ITER - 1)) begin
          res_d   = p_d[2*WIDTH-1:0];
          state_d = DONE;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      q_q     <= '0;
      g_q     <= 1'b0;
      p_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      g_q     <= g_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign result    = res_q;
endmodule

// File: tb/tb_seq_booth_multiplier.sv
// tb_seq_booth_multiplier: directed 8-bit vectors and corner sequences, plus a 16-bit random run against a product model.
module tb_seq_booth_multiplier;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic iv8 = 1'b0, sm8 = 1'b0, or8 = 1'b1;
  logic ir8, ov8, busy8;
  logic [7:0] m8 = '0, q8 = '0;
  logic [15:0] res8;
  logic iv16 = 1'b0, sm16 = 1'b0, or16 = 1'b0;
  logic ir16, ov16, busy16;
  logic [15:0] m16 = '0, q16 = '0;
  logic [31:0] res16;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic        sm;
    logic [7:0]  m;
    logic [7:0]  q;
    logic [15:0] exp;
  } vec_t;
  seq_booth_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .signed_mode(sm8), .M(m8), .Q(q8),
    .out_valid(ov8), .out_ready(or8), .result(res8), .busy(busy8)
  );
  seq_booth_multiplier #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .signed_mode(sm16), .M(m16), .Q(q16),
    .out_valid(ov16), .out_ready(or16), .result(res16), .busy(busy16)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] ref16(input logic sm, input logic [15:0] a, input logic [15:0] b);
    longint pa, pb;
    pa = sm ? longint'($signed(a)) : longint'({48'b0, a});
    pb = sm ? longint'($signed(b)) : longint'({48'b0, b});
    return 32'(pa * pb);
  endfunction
  task automatic run8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                      output logic [15:0] r, output int lat);
    @(negedge clk);
    for (int n = 0; !ir8 && n < 50; n++) @(negedge clk);
    sm8 = sm; m8 = a; q8 = b; iv8 = 1'b1;
    @(posedge clk);
    #1 iv8 = 1'b0;
    lat = 0;
    while (!ov8 && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    r = res8;
  endtask
  task automatic run16(input logic sm, input logic [15:0] a, input logic [15:0] b, input int stall);
    int lat;
    @(negedge clk);
    for (int n = 0; !ir16 && n < 50; n++) @(negedge clk);
    sm16 = sm; m16 = a; q16 = b; iv16 = 1'b1;
    @(posedge clk);
    #1 iv16 = 1'b0;
    m16 = 16'($urandom); q16 = 16'($urandom); sm16 = ~sm;
    lat = 0;
    while (!ov16 && lat < 30) begin
      @(posedge clk);
      #1 lat++;
    end
    check("lat16", lat, 9);
    repeat (stall) @(posedge clk);
    #1;
    check("hold16", {31'b0, ov16}, 1);
    check("res16", res16, ref16(sm, a, b));
    @(negedge clk) or16 = 1'b1;
    @(posedge clk);
    #1 or16 = 1'b0;
    check("ack16", {31'b0, ov16}, 0);
  endtask
  initial begin
    vec_t tbl[13];
    logic [15:0] r;
    int lat;
    tbl = '{
      '{1'b1, 8'h03, 8'h05, 16'h000F},
      '{1'b1, 8'h80, 8'h80, 16'h4000},
      '{1'b1, 8'h80, 8'h7F, 16'hC080},
      '{1'b0, 8'hFF, 8'hFF, 16'hFE01},
      '{1'b1, 8'hFF, 8'hFF, 16'h0001},
      '{1'b1, 8'h02, 8'hFD, 16'hFFFA},
      '{1'b0, 8'h80, 8'h80, 16'h4000},
      '{1'b0, 8'h00, 8'hFF, 16'h0000},
      '{1'b1, 8'h7F, 8'h7F, 16'h3F01},
      '{1'b0, 8'hFF, 8'h01, 16'h00FF},
      '{1'b1, 8'hFF, 8'h01, 16'hFFFF},
      '{1'b1, 8'h7F, 8'h80, 16'hC080},
      '{1'b0, 8'h12, 8'h34, 16'h03A8}
    };
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'b0, ir8}, 1);
    check("rst_out_valid", {31'b0, ov8}, 0);
    check("rst_busy", {31'b0, busy8}, 0);
    check("rst_result", {16'b0, res8}, 0);
    rst = 1'b0;
    foreach (tbl[i]) begin
      run8(tbl[i].sm, tbl[i].m, tbl[i].q, r, lat);
      check($sformatf("vec%0d_result", i), {16'b0, r}, {16'b0, tbl[i].exp});
      check($sformatf("vec%0d_latency", i), lat, 5);
      @(posedge clk);
      #1 check($sformatf("vec%0d_idle", i), {31'b0, ir8}, 1);
    end
    or8 = 1'b0;
    run8(1'b0, 8'h0A, 8'h0B, r, lat);
    check("bp_latency", lat, 5);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_out_valid", {31'b0, ov8}, 1);
      check("bp_result", {16'b0, res8}, 32'h006E);
      check("bp_in_ready", {31'b0, ir8}, 0);
      iv8 = c[0]; m8 = 8'(c * 7 + 1); q8 = 8'(c + 3); sm8 = c[1];
    end
    @(negedge clk);
    iv8 = 1'b0; or8 = 1'b1;
    @(posedge clk);
    #1;
    check("bp_ack_out_valid", {31'b0, ov8}, 0);
    check("bp_ack_in_ready", {31'b0, ir8}, 1);
    check("bp_result_kept", {16'b0, res8}, 32'h006E);
    @(negedge clk);
    sm8 = 1'b1; m8 = 8'h12; q8 = 8'h34; iv8 = 1'b1;
    @(posedge clk);
    #1 iv8 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_in_ready", {31'b0, ir8}, 1);
    check("midrst_out_valid", {31'b0, ov8}, 0);
    check("midrst_busy", {31'b0, busy8}, 0);
    check("midrst_result", {16'b0, res8}, 0);
    @(negedge clk) rst = 1'b0;
    run8(1'b1, 8'h02, 8'hFD, r, lat);
    check("post_rst_result", {16'b0, r}, 32'hFFFA);
    check("post_rst_latency", lat, 5);
    run16(1'b1, 16'h8000, 16'h8000, 0);
    run16(1'b0, 16'hFFFF, 16'hFFFF, 2);
    run16(1'b1, 16'hFFFF, 16'h7FFF, 1);
    for (int i = 0; i < 300; i++)
      run16(1'($urandom), 16'($urandom), 16'($urandom), int'($urandom_range(0, 3)));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
